// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter
// Round-robin arbiter sharing one 16:1 W-bit data mux between 16 requesters.
// The winning index is registered as sel. The selected word is presented on a
// single valid/ready port. A one-cycle ack is returned to the requester whose
// word was taken.
//
// Optional feature macro: ARB_BURST_EN. When it is defined, a requester that
// keeps req asserted may take up to MAX_BURST back-to-back transfers before the
// grant rotates.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   req[15:0]     per-requester request
//   in[16*W-1:0]  packed words, requester i at in[i*W +: W]
//   out_ready     downstream accepts out_data this cycle
//   out_valid     out_data holds a granted word
//   out_data      word of the currently selected requester
//   sel[3:0]      registered mux select
//   gnt[15:0]     one-hot grant (1<<sel while out_valid)
//   ack[15:0]     one-cycle pulse, one cycle after the transfer
module mux16_rr_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     req,
    input  logic [16*W-1:0] in,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [3:0]      sel,
    output logic [15:0]     gnt,
    output logic [15:0]     ack
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [15:0] ack_q, ack_d;
    logic [15:0] others;   // req with the current winner masked off
    logic        rotate;

`ifdef ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // First set bit of mask, searching upward from ptr and wrapping modulo 16.
    function automatic logic [3:0] pick(input logic [15:0] mask, input logic [3:0] ptr);
        logic [3:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        rotate  = 1'b0;
        others  = req & ~(16'h1 << sel_q);
`ifdef ARB_BURST_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ARB_BURST_EN
                cnt_d = '0;
`endif
                if (|req) begin
                    sel_d   = pick(req, ptr_q);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    // Requester withdrew before the transfer. This also wins
                    // over out_ready, so no ack is sent and ptr is kept.
                    state_d = IDLE;
`ifdef ARB_BURST_EN
                    cnt_d = '0;
`endif
                end else if (out_ready) begin
                    ack_d = 16'h1 << sel_q;
                    ptr_d = sel_q + 4'd1;
`ifdef ARB_BURST_EN
                    // req[sel] is known high here, so only the burst length
                    // decides between staying and rotating.
                    if (int'(cnt_q) + 1 < MAX_BURST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d  = '0;
                        rotate = 1'b1;
                    end
`else
                    rotate = 1'b1;
`endif
                end
                if (rotate) begin
                    if (|others) sel_d = pick(others, sel_q + 4'd1);
                    else         state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
        end
    end

`ifdef ARB_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign out_valid = (state_q == GRANT);
    assign sel       = sel_q;
    assign gnt       = out_valid ? (16'h1 << sel_q) : 16'h0;
    assign ack       = ack_q;
    assign out_data  = in[sel_q*W +: W];

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
module tb_mux16_rr_arbiter;
    localparam int W = 8;

    logic            clk;
    logic            rst_n;
    logic [15:0]     req;
    logic [16*W-1:0] in_bus;
    logic            out_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [3:0]      sel;
    logic [15:0]     gnt;
    logic [15:0]     ack;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] exp_seq [9];

    mux16_rr_arbiter #(.W(W), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in        (in_bus),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .gnt       (gnt),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 16'hFFFF;
        out_ready = 1'b0;
        in_bus    = '0;
        for (int i = 0; i < 16; i++) in_bus[i*W +: W] = 8'(8'h10 + i);

        // Reset state with every request asserted
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_gnt",   32'(gnt),       32'h0);
        chk("rst_ack",   32'(ack),       32'h0);
        chk("rst_sel",   32'(sel),       32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_valid", 32'(out_valid), 32'h1);
        chk("rel_sel",   32'(sel),       32'h0);
        chk("rel_gnt",   32'(gnt),       32'h1);
        req = 16'h0;                       // abort back to IDLE, ptr stays 0
        @(negedge clk);
        chk("rel_abort_valid", 32'(out_valid), 32'h0);
        chk("rel_abort_ack",   32'(ack),       32'h0);

        // Two requesters, downstream always ready
        req = 16'h0011; out_ready = 1'b1;
        @(negedge clk);
        chk("rr_sel0",  32'(sel),      32'h0);
        chk("rr_data0", 32'(out_data), 32'h10);
        chk("rr_ack0",  32'(ack),      32'h0);
        @(negedge clk);
`ifdef ARB_BURST_EN
        chk("rr_sel1", 32'(sel), 32'h0);
        chk("rr_ack1", 32'(ack), 32'h0001);
        @(negedge clk);
        chk("rr_sel2", 32'(sel), 32'h0);
        chk("rr_ack2", 32'(ack), 32'h0001);
        @(negedge clk);
        chk("rr_sel3", 32'(sel), 32'h0);
        chk("rr_ack3", 32'(ack), 32'h0001);
`else
        chk("rr_sel1",  32'(sel),      32'h4);
        chk("rr_ack1",  32'(ack),      32'h0001);
        chk("rr_data1", 32'(out_data), 32'h14);
        @(negedge clk);
        chk("rr_sel2", 32'(sel), 32'h0);
        chk("rr_ack2", 32'(ack), 32'h0010);
        @(negedge clk);
        chk("rr_sel3", 32'(sel), 32'h4);
        chk("rr_ack3", 32'(ack), 32'h0001);
`endif
        req = 16'h0;                       // abort: ptr left at 1
        @(negedge clk);
        chk("rr_end_valid", 32'(out_valid), 32'h0);
        chk("rr_end_ack",   32'(ack),       32'h0);

        // Requester 15 with stalled downstream, then wrap of ptr
        req = 16'h8000; out_ready = 1'b0; in_bus[15*W +: W] = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_sel",   32'(sel),       32'hF);
            chk("stall_data",  32'(out_data),  32'hA5);
            chk("stall_gnt",   32'(gnt),       32'h8000);
            chk("stall_ack",   32'(ack),       32'h0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("r15_ack", 32'(ack), 32'h8000);
`ifdef ARB_BURST_EN
        chk("r15_valid", 32'(out_valid), 32'h1);
`else
        chk("r15_valid", 32'(out_valid), 32'h0);
`endif
        req = 16'h8001; out_ready = 1'b0;
        @(negedge clk);
        chk("wrap_valid", 32'(out_valid), 32'h1);
`ifdef ARB_BURST_EN
        chk("wrap_sel", 32'(sel), 32'hF);
`else
        chk("wrap_sel", 32'(sel), 32'h0);
`endif
        chk("wrap_ack", 32'(ack), 32'h0);
        req = 16'h0;
        @(negedge clk);
        chk("wrap_end_valid", 32'(out_valid), 32'h0);

        // Abort of requester 3 leaves ptr untouched
        req = 16'h0008;
        @(negedge clk);
        chk("ab_sel",   32'(sel),       32'h3);
        chk("ab_valid", 32'(out_valid), 32'h1);
        req = 16'h0;
        @(negedge clk);
        chk("ab_valid_off", 32'(out_valid), 32'h0);
        chk("ab_ack",       32'(ack),       32'h0);
        chk("ab_gnt",       32'(gnt),       32'h0);
        req = 16'h0018;                    // ptr 0 picks 3; a moved ptr would pick 4
        @(negedge clk);
        chk("ab_ptr_sel", 32'(sel), 32'h3);
        req = 16'h0;
        @(negedge clk);

        // Requesters 1 and 2 continuously, downstream always ready
`ifdef ARB_BURST_EN
        exp_seq = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1};
`else
        exp_seq = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
`endif
        req = 16'h0006; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk($sformatf("seq_sel%0d", k), 32'(sel), 32'(exp_seq[k]));
        end
        req = 16'h0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset asserted mid-GRANT drops the word with no ack
        req = 16'h0004;
        @(negedge clk);
        chk("mid_sel", 32'(sel), 32'h2);
        rst_n = 1'b0; out_ready = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_sel",   32'(sel),       32'h0);
        req = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack",   32'(ack),       32'h0);
        chk("mid_rst_idle",  32'(out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter that shares one 16:1 W-bit data mux between 16 requesters.
- Registers the mux select and presents the selected word on a single valid/ready output port.
- Returns a one-cycle ack to the requester whose word was taken.
- Sits in front of shared pipeline resources, e.g. a writeback/result bus fed by multiple sources.

Parameters:
W, 8, data width of each requester word and of out_data
MAX_BURST, 4, max consecutive transfers granted to one requester (used only with ARB_BURST_EN)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  16  request per requester; bit i = requester i
in  input  16*W  packed words; requester i at in[i*W +: W]
out_ready  input  1  downstream accepts out_data this cycle
out_valid  output  1  out_data holds a granted word
out_data  output  W  word of the currently selected requester
sel  output  4  registered mux select (index of granted requester)
gnt  output  16  one-hot grant, equals 1<<sel while out_valid, else 0
ack  output  16  one-hot, 1-cycle pulse marking the requester whose word transferred

Behaviour:
- Reset (async, rst_n=0) forces these values:
  - state=IDLE, sel=0, ptr=0, out_valid=0, gnt=0, ack=0.
  - Burst count=0.
  - Deassertion takes effect on the next clk edge.
- out_data = in[sel*W +: W], combinational from registered sel. It is don't-care when out_valid=0.
- Arbitration function pick(mask, ptr): returns the lowest index i, searching ptr, ptr+1, ..., 15, 0, ..., ptr-1 modulo 16, with mask[i]=1.
- States:
  - IDLE:
    - out_valid=0.
    - If |req, then sel<=pick(req, ptr) and go to GRANT.
    - Latency from first req edge to out_valid is 1 cycle.
  - GRANT:
    - out_valid=1, gnt=1<<sel.
    - Transfer occurs when out_valid & out_ready. On transfer:
      - ack[sel] pulses 1 the next cycle.
      - ptr<=sel+1, mod 16, so 15 wraps to 0.
      - Let m = req with bit sel cleared. If |m, then sel<=pick(m, sel+1) and stay in GRANT (back-to-back, 1 word/cycle). Otherwise go to IDLE.
    - Without transfer (out_ready=0): hold sel, out_valid and gnt; out_data stays stable as long as the requester holds in stable.
    - Abort: req[sel]=0 while in GRANT with no transfer. Go to IDLE, no ack, ptr unchanged.
    - Abort and out_ready=1 in the same cycle: the transfer is treated as not occurring; out_valid is still 1 that cycle and downstream sees the word. Requesters must hold req until ack, so this case is a protocol violation; the defined response is abort.
- Requester rule: hold req[i] and its word until ack[i]. Deassert req[i] in the ack cycle, or keep it asserted to request again.
- Fairness: a requester asserting req continuously is granted within 16 transfers.
- ack and gnt are never both targeting different requesters for the same word. ack lags the transfer by exactly 1 cycle.
- Reset asserted mid-GRANT drops the pending word silently; no ack is issued.

Optional Feature:
- ARB_BURST_EN defined:
  - On transfer, if req[sel]=1 and burst count+1 < MAX_BURST, keep the same sel, increment the count and stay in GRANT.
  - Otherwise reset the count and rotate as in base behaviour.
  - Count clears on every sel change, on IDLE and on reset.
- ARB_BURST_EN not defined: strict rotation after every transfer; MAX_BURST is ignored.

Test Plan:
- Reset with req=16'hFFFF: out_valid=0, gnt=0, ack=0, sel=0 while rst_n=0. After release, out_valid=1 one cycle later with sel=0.
- req=16'h0011, out_ready=1 steady: sel sequence 0,4,0,4 on consecutive cycles. ack pulses 16'h0001, 16'h0010 alternately, each one cycle after the transfer.
- Single req[15]=1, in[15*W+:W]=8'hA5, out_ready=0 for 3 cycles then 1: out_valid held, out_data=8'hA5 stable. One ack[15] follows the transfer; ptr wraps to 0. Next req=16'h8001 grants sel=0 first.
- req[3] granted, then req[3] dropped with out_ready=0: state returns to IDLE next cycle, no ack, ptr unchanged.
- ARB_BURST_EN, MAX_BURST=4, req=16'h0006, out_ready=1: sel=1 for 4 cycles, then sel=2 for 4 cycles, then sel=1.
- Without ARB_BURST_EN, same stimulus: sel alternates 1,2,1,2.
